// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 instruction transmitter.
// Holds the FSM state type, default timings, db field positions and command decode.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP,
    ST_WAIT
  } lcd_state_e;

  localparam int SETUP_CYC_DEF      = 2;
  localparam int E_HIGH_CYC_DEF     = 12;
  localparam int HOLD_CYC_DEF       = 1;
  localparam int NIBBLE_GAP_CYC_DEF = 50;
  localparam int CMD_WAIT_CYC_DEF   = 2000;
  localparam int LONG_WAIT_CYC_DEF  = 82000;

  localparam int DB_RS = 9;
  localparam int DB_RW = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
  function automatic logic is_long_cmd(input logic [9:0] db);
    return (db[9:2] == 8'h00) && (db[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that times each transmitter phase.
// A load restarts the count; it then decrements to zero and holds there.
module lcd_delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_instr_tx.sv
// HD44780 instruction transmitter: one 10-bit {RS,RW,D7..D0} word per handshake,
// sent as one 8-bit or two 4-bit strobes followed by the controller settle wait.
//
// state  | meaning
// IDLE   | ready for a word, E low, RS/RW/SF_D hold last values
// SETUP  | RS/RW/SF_D stable before E rises
// STROBE | E high
// HOLD   | E low, data held
// GAP    | pause between upper and lower nibble (4-bit bus)
// WAIT   | controller executing; done pulses on exit
module lcd_instr_tx
  import lcd_pkg::*;
#(
  parameter int BUS_WIDTH      = 4,
  parameter int SETUP_CYC      = SETUP_CYC_DEF,
  parameter int E_HIGH_CYC     = E_HIGH_CYC_DEF,
  parameter int HOLD_CYC       = HOLD_CYC_DEF,
  parameter int NIBBLE_GAP_CYC = NIBBLE_GAP_CYC_DEF,
  parameter int CMD_WAIT_CYC   = CMD_WAIT_CYC_DEF,
  parameter int LONG_WAIT_CYC  = LONG_WAIT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [9:0]           db,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  output logic                 LCD_E,
  output logic [BUS_WIDTH-1:0] SF_D,
  output logic                 done
);

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, E_HIGH_CYC), max2(HOLD_CYC, NIBBLE_GAP_CYC)),
                                max2(CMD_WAIT_CYC, LONG_WAIT_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
    $error("lcd_instr_tx: BUS_WIDTH must be 4 or 8");
  end

  lcd_state_e       state_q, state_d;
  logic             nib_lo_q, nib_lo_d;
  logic [9:0]       word_q;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             cnt_zero;
  logic             take;

  assign take = (state_q == ST_IDLE) && instr_valid;

  lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      nib_lo_q <= 1'b0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      nib_lo_q <= nib_lo_d;
      if (take) word_q <= db;
    end
  end

  // Every state entry reloads the counter with (phase length - 1).
  always_comb begin
    state_d  = state_q;
    nib_lo_d = nib_lo_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      ST_IDLE: if (instr_valid) begin
        state_d  = ST_SETUP;
        nib_lo_d = 1'b0;
        load     = 1'b1;
        load_val = CNT_W'(SETUP_CYC - 1);
      end
      ST_SETUP: if (cnt_zero) begin
        state_d  = ST_STROBE;
        load     = 1'b1;
        load_val = CNT_W'(E_HIGH_CYC - 1);
      end
      ST_STROBE: if (cnt_zero) begin
        state_d  = ST_HOLD;
        load     = 1'b1;
        load_val = CNT_W'(HOLD_CYC - 1);
      end
      ST_HOLD: if (cnt_zero) begin
        load = 1'b1;
        if (BUS_WIDTH == 4 && !nib_lo_q) begin
          state_d  = ST_GAP;
          load_val = CNT_W'(NIBBLE_GAP_CYC - 1);
        end else begin
          state_d  = ST_WAIT;
          load_val = is_long_cmd(word_q) ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
        end
      end
      ST_GAP: if (cnt_zero) begin
        state_d  = ST_SETUP;
        nib_lo_d = 1'b1;
        load     = 1'b1;
        load_val = CNT_W'(SETUP_CYC - 1);
      end
      ST_WAIT: if (cnt_zero) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly on the clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      LCD_RS      <= 1'b0;
      LCD_RW      <= 1'b0;
      LCD_E       <= 1'b0;
      SF_D        <= '0;
      done        <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      LCD_E       <= (state_d == ST_STROBE);
      done        <= (state_q == ST_WAIT) && cnt_zero;
      instr_ready <= (state_d == ST_IDLE);
      if (take) begin
        LCD_RS <= db[DB_RS];
        LCD_RW <= db[DB_RW];
        SF_D   <= BUS_WIDTH'(db[7:0] >> (8 - BUS_WIDTH));
      end else if (state_q == ST_GAP && cnt_zero) begin
        SF_D   <= BUS_WIDTH'(word_q[7:0]);
      end
    end
  end

endmodule
